adxl345_cmd_sequencer: RTL and testbench

- Upstream controller for the ADXL345 SPI master; owns the command-select levels and the transaction request (CS1) that the master consumes.
- After reset, runs the fixed init sequence: DATA_FORMAT write, BW_RATE write, POWER_CTL measure-mode write.
- Then polls the axis-data read at a programmable interval and captures the master's parallel MISO word into a valid-pulsed sample register.
- Sits between the board top level (enable/status) and the SPI master.

---
 rtl/adxl345_pkg.sv | 57 +++++
 rtl/adxl345_cmd_sequencer_if.sv | 32 +++
 rtl/adxl345_xfer_ctrl.sv | 120 ++++++++++++
 rtl/adxl345_cmd_sequencer.sv | 116 +++++++++++
 tb/tb_adxl345_cmd_sequencer.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adxl345_pkg.sv
// rtl/adxl345_pkg.sv - shared states, select codes and ADXL345 register map for the command sequencer
package adxl345_pkg;

  typedef enum logic [2:0] {
    T_PWRUP,
    T_FMT,
    T_RATE,
    T_MEAS,
    T_IDLE,
    T_AXIS,
    T_POLL
  } top_state_e;

  typedef enum logic [2:0] {
    X_IDLE,
    X_SETUP,
    X_REQ,
    X_BUSY,
    X_GAP
  } xfer_state_e;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_FORMAT,
    SEL_RATE,
    SEL_MEASURE,
    SEL_AXIS
  } sel_code_e;

  // Registers the SPI master addresses for each select line.
  localparam logic [7:0] REG_DATA_FORMAT = 8'h31;
  localparam logic [7:0] REG_BW_RATE     = 8'h2C;
  localparam logic [7:0] REG_POWER_CTL   = 8'h2D;
  localparam logic [7:0] REG_DATAX0      = 8'h32;

  // Bit order: {axis, measure, rate, format}.
  function automatic logic [3:0] sel_onehot(input sel_code_e code);
    case (code)
      SEL_FORMAT:  return 4'b0001;
      SEL_RATE:    return 4'b0010;
      SEL_MEASURE: return 4'b0100;
      SEL_AXIS:    return 4'b1000;
      default:     return 4'b0000;
    endcase
  endfunction

  function automatic sel_code_e sel_for_state(input top_state_e s);
    case (s)
      T_FMT:   return SEL_FORMAT;
      T_RATE:  return SEL_RATE;
      T_MEAS:  return SEL_MEASURE;
      T_AXIS:  return SEL_AXIS;
      default: return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/adxl345_cmd_sequencer_if.sv
// rtl/adxl345_cmd_sequencer_if.sv - select/request/CS/MISO bundle between sequencer and SPI master
interface adxl345_cmd_sequencer_if;

  logic        sel_format;
  logic        sel_rate;
  logic        sel_measure;
  logic        sel_axis;
  logic        spi_start;
  logic        cs_n;
  logic [15:0] miso_data;

  modport master (
    output sel_format,
    output sel_rate,
    output sel_measure,
    output sel_axis,
    output spi_start,
    input  cs_n,
    input  miso_data
  );

  modport slave (
    input  sel_format,
    input  sel_rate,
    input  sel_measure,
    input  sel_axis,
    input  spi_start,
    output cs_n,
    output miso_data
  );

endinterface

// File: rtl/adxl345_xfer_ctrl.sv
// rtl/adxl345_xfer_ctrl.sv - SETUP/REQ/BUSY/GAP handshake with the SPI master, with CS timeout
module adxl345_xfer_ctrl
  import adxl345_pkg::*;
#(
  parameter int SETUP_CYC   = 4,
  parameter int GAP_CYC     = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  sel_code_e  sel_code,
  input  logic       cs_n,
  output logic [3:0] sel_vec,
  output logic       spi_start,
  output logic       done,
  output logic       timed_out,
  output logic       capture
);

  localparam int CMAX_SG = (SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC;
  localparam int CMAX    = (TIMEOUT_CYC > CMAX_SG) ? TIMEOUT_CYC : CMAX_SG;
  localparam int CW      = $clog2(CMAX + 1);

  localparam logic [CW-1:0] SETUP_END = CW'(SETUP_CYC);
  localparam logic [CW-1:0] GAP_END   = CW'(GAP_CYC);
  localparam logic [CW-1:0] TO_END    = CW'(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_SAT   = CW'(CMAX);

  xfer_state_e     state, state_n;
  sel_code_e       cur_sel, cur_sel_n;
  logic [CW-1:0]   cnt, cnt_n, cnt_inc;

  assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= X_IDLE;
      cur_sel <= SEL_NONE;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      cur_sel <= cur_sel_n;
      cnt     <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cur_sel_n = cur_sel;
    cnt_n     = cnt_inc;
    done      = 1'b0;
    timed_out = 1'b0;
    capture   = 1'b0;
    case (state)
      X_IDLE: begin
        cnt_n = '0;
        if (go) begin
          state_n   = X_SETUP;
          cur_sel_n = sel_code;
        end
      end
      X_SETUP: begin
        if (cnt_inc == SETUP_END) begin
          state_n = X_REQ;
          cnt_n   = '0;
        end
      end
      X_REQ: begin
        if (!cs_n) begin
          state_n = X_BUSY;
          cnt_n   = '0;
        end else if (cnt_inc == TO_END) begin
          state_n   = X_GAP;
          cnt_n     = '0;
          timed_out = 1'b1;
        end
      end
      X_BUSY: begin
        if (cs_n) begin
          state_n = X_GAP;
          cnt_n   = '0;
          capture = 1'b1;
        end else if (cnt_inc == TO_END) begin
          state_n   = X_GAP;
          cnt_n     = '0;
          timed_out = 1'b1;
        end
      end
      X_GAP: begin
        if (cnt_inc == GAP_END) begin
          done  = 1'b1;
          cnt_n = '0;
          // Back-to-back launch lets the next command start without an idle cycle.
          if (go) begin
            state_n   = X_SETUP;
            cur_sel_n = sel_code;
          end else begin
            state_n = X_IDLE;
          end
        end
      end
      default: begin
        state_n = X_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // The select stays up from SETUP through BUSY so the master's parameters never move mid-transfer.
  always_comb begin
    sel_vec = 4'b0000;
    if (state == X_SETUP || state == X_REQ || state == X_BUSY) begin
      sel_vec = sel_onehot(cur_sel);
    end
  end

  assign spi_start = (state == X_REQ);

endmodule

// File: rtl/adxl345_cmd_sequencer.sv
// rtl/adxl345_cmd_sequencer.sv - ADXL345 init sequence and periodic axis-data polling for the SPI master
module adxl345_cmd_sequencer
  import adxl345_pkg::*;
#(
  parameter int POWERUP_CYC = 200000,
  parameter int SETUP_CYC   = 4,
  parameter int GAP_CYC     = 16,
  parameter int POLL_CYC    = 1000000,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  adxl345_cmd_sequencer_if.master         spi,
  output logic                            init_done,
  output logic [15:0]                     sample_data,
  output logic                            sample_valid,
  output logic                            error
);

  localparam int TCMAX = (POWERUP_CYC > POLL_CYC) ? POWERUP_CYC : POLL_CYC;
  localparam int TCW   = $clog2(TCMAX + 1);

  localparam logic [TCW-1:0] PWR_END  = TCW'(POWERUP_CYC);
  localparam logic [TCW-1:0] POLL_END = TCW'(POLL_CYC);
  localparam logic [TCW-1:0] TCNT_SAT = TCW'(TCMAX);

  top_state_e      state, state_n;
  logic [TCW-1:0]  tcnt, tcnt_n, tcnt_inc;
  logic            xfer_to;
  logic            go;
  sel_code_e       sel_code;
  logic [3:0]      sel_vec;
  logic            x_done, x_timed_out, x_capture;

  adxl345_xfer_ctrl #(
    .SETUP_CYC   (SETUP_CYC),
    .GAP_CYC     (GAP_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_xfer (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .sel_code  (sel_code),
    .cs_n      (spi.cs_n),
    .sel_vec   (sel_vec),
    .spi_start (spi.spi_start),
    .done      (x_done),
    .timed_out (x_timed_out),
    .capture   (x_capture)
  );

  assign spi.sel_format  = sel_vec[0];
  assign spi.sel_rate    = sel_vec[1];
  assign spi.sel_measure = sel_vec[2];
  assign spi.sel_axis    = sel_vec[3];

  assign tcnt_inc = (tcnt == TCNT_SAT) ? tcnt : tcnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= T_PWRUP;
      tcnt         <= '0;
      xfer_to      <= 1'b0;
      init_done    <= 1'b0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      error        <= 1'b0;
    end else begin
      state        <= state_n;
      tcnt         <= tcnt_n;
      sample_valid <= x_capture && (state == T_AXIS);
      if (go) begin
        xfer_to <= 1'b0;
      end else if (x_timed_out) begin
        xfer_to <= 1'b1;
      end
      if (x_timed_out) begin
        error <= 1'b1;
      end
      if (x_capture && state == T_MEAS) begin
        init_done <= 1'b1;
      end
      if (x_capture && state == T_AXIS) begin
        sample_data <= spi.miso_data;
      end
    end
  end

  always_comb begin
    state_n  = state;
    tcnt_n   = tcnt_inc;
    go       = 1'b0;
    sel_code = SEL_NONE;
    case (state)
      T_PWRUP: if (tcnt_inc == PWR_END) state_n = T_FMT;
      // Any init-write timeout replays the whole init from the format write.
      T_FMT:   if (x_done) state_n = xfer_to ? T_FMT : T_RATE;
      T_RATE:  if (x_done) state_n = xfer_to ? T_FMT : T_MEAS;
      T_MEAS:  if (x_done) state_n = xfer_to ? T_FMT : T_IDLE;
      T_IDLE:  if (enable) state_n = T_AXIS;
      T_AXIS:  if (x_done) state_n = T_POLL;
      T_POLL:  if (tcnt_inc == POLL_END) state_n = enable ? T_AXIS : T_IDLE;
      default: state_n = T_PWRUP;
    endcase
    if (state_n != state) begin
      tcnt_n = '0;
    end
    // Launch on the edge that enters a command state, including a retry of the same state.
    if (sel_for_state(state_n) != SEL_NONE && (state_n != state || x_done)) begin
      go       = 1'b1;
      sel_code = sel_for_state(state_n);
    end
  end

endmodule

// File: tb/tb_adxl345_cmd_sequencer.sv
// tb/tb_adxl345_cmd_sequencer.sv - directed bench with a behavioural SPI master model
module tb_adxl345_cmd_sequencer;
  import adxl345_pkg::*;

  localparam int POWERUP_CYC = 10;
  localparam int SETUP_CYC   = 4;
  localparam int GAP_CYC     = 3;
  localparam int POLL_CYC    = 20;
  localparam int TIMEOUT_CYC = 50;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        init_done;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        error;

  logic [15:0] axis_word;
  logic        block_rate;

  int n_checks;
  int n_fail;
  int onehot_viol;
  int sv_count;
  int sv_multi;
  int sel_log[$];

  adxl345_cmd_sequencer_if spi_if ();

  adxl345_cmd_sequencer #(
    .POWERUP_CYC (POWERUP_CYC),
    .SETUP_CYC   (SETUP_CYC),
    .GAP_CYC     (GAP_CYC),
    .POLL_CYC    (POLL_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .spi          (spi_if.master),
    .init_done    (init_done),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int cur_sel();
    int n;
    n = int'(spi_if.sel_format) + int'(spi_if.sel_rate) + int'(spi_if.sel_measure) + int'(spi_if.sel_axis);
    if (n > 1) return 7;
    if (spi_if.sel_format) return 1;
    if (spi_if.sel_rate) return 2;
    if (spi_if.sel_measure) return 3;
    if (spi_if.sel_axis) return 4;
    return 0;
  endfunction

  task automatic wait_sel(input int code, input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cur_sel() != code && n < max);
  endtask

  task automatic wait_cs(input logic lvl, input int max);
    int n;
    n = 0;
    while (spi_if.cs_n !== lvl && n < max) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_sv(input int max);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_valid && n < max);
  endtask

  task automatic count_setup(output int s);
    s = 0;
    for (int k = 0; k < 50; k++) begin
      if (spi_if.spi_start) break;
      if (cur_sel() != 0) s++;
      @(negedge clk);
    end
  endtask

  // SPI master model: CS low two cycles after the request, held 30 cycles, MISO word presented at CS rise.
  initial begin
    spi_if.cs_n      = 1'b1;
    spi_if.miso_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (spi_if.spi_start && !rst && !(block_rate && spi_if.sel_rate)) begin
        @(posedge clk);
        #1;
        if (!rst) begin
          spi_if.cs_n = 1'b0;
          for (int i = 0; i < 30 && !rst; i++) begin
            @(posedge clk);
            #1;
          end
          spi_if.miso_data = axis_word;
          spi_if.cs_n      = 1'b1;
        end
      end
    end
  end

  initial begin
    int prev_code;
    logic prev_sv;
    int c;
    prev_code = 0;
    prev_sv   = 1'b0;
    forever begin
      @(negedge clk);
      c = cur_sel();
      if (c == 7) onehot_viol++;
      if (c != 0 && c != 7 && c != prev_code) sel_log.push_back(c);
      prev_code = c;
      if (sample_valid) begin
        sv_count++;
        if (prev_sv) sv_multi++;
      end
      prev_sv = sample_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int s;
    int sv_before;
    int starts;

    n_checks    = 0;
    n_fail      = 0;
    onehot_viol = 0;
    sv_count    = 0;
    sv_multi    = 0;
    axis_word   = 16'hA55A;
    block_rate  = 1'b0;
    rst         = 1'b1;
    enable      = 1'b1;

    repeat (3) @(negedge clk);
    check_val("rst_sel", cur_sel(), 0);
    check_val("rst_spi_start", spi_if.spi_start, 0);
    check_val("rst_init_done", init_done, 0);
    check_val("rst_sample_valid", sample_valid, 0);
    check_val("rst_sample_data", sample_data, 16'h0000);
    check_val("rst_error", error, 0);

    rst = 1'b0;
    wait_sel(1, 100, n);
    check_val("pwrup_latency", n, POWERUP_CYC);
    count_setup(s);
    check_val("fmt_setup_cycles", s, SETUP_CYC);

    wait_sel(3, 400, n);
    check_val("meas_sel_seen", cur_sel(), 3);
    wait_cs(1'b0, 100);
    wait_cs(1'b1, 100);
    check_val("init_done_before_cs_rise", init_done, 0);
    @(negedge clk);
    check_val("init_done_after_cs_rise", init_done, 1);
    check_val("init_sel_order_len", sel_log.size(), 3);
    if (sel_log.size() == 3) begin
      check_val("init_sel_0", sel_log[0], 1);
      check_val("init_sel_1", sel_log[1], 2);
      check_val("init_sel_2", sel_log[2], 3);
    end
    check_val("init_no_sample_valid", sv_count, 0);

    wait_sv(300);
    check_val("axis1_valid", sample_valid, 1);
    check_val("axis1_data", sample_data, 16'hA55A);
    axis_word = 16'h1234;
    @(negedge clk);
    check_val("axis1_pulse_width", sample_valid, 0);
    n = 1;
    while (!spi_if.sel_axis && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("pulse_to_next_axis", n, GAP_CYC + POLL_CYC);

    wait_sv(300);
    check_val("axis2_valid", sample_valid, 1);
    check_val("axis2_data", sample_data, 16'h1234);

    axis_word = 16'h0FF0;
    wait_sel(4, 200, n);
    wait_cs(1'b0, 100);
    check_val("gate_mid_axis", int'(spi_if.sel_axis && !spi_if.cs_n), 1);
    sv_before = sv_count;
    enable = 1'b0;
    wait_sv(300);
    check_val("gate_last_valid", sample_valid, 1);
    check_val("gate_last_data", sample_data, 16'h0FF0);
    starts = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (spi_if.spi_start) starts++;
    end
    check_val("gate_no_spi_start", starts, 0);
    check_val("gate_one_sample", sv_count - sv_before, 1);

    enable = 1'b1;
    wait_sel(4, 50, n);
    check_val("resume_latency", n, 1);
    count_setup(s);
    check_val("resume_setup_cycles", s, SETUP_CYC);

    wait_cs(1'b0, 100);
    check_val("rst_mid_cs_low", spi_if.cs_n, 0);
    rst = 1'b1;
    @(negedge clk);
    check_val("rstmid_sel", cur_sel(), 0);
    check_val("rstmid_spi_start", spi_if.spi_start, 0);
    check_val("rstmid_init_done", init_done, 0);
    check_val("rstmid_sample_data", sample_data, 16'h0000);
    check_val("rstmid_error", error, 0);
    @(negedge clk);
    block_rate = 1'b1;
    rst = 1'b0;
    wait_sel(1, 100, n);
    check_val("replay_pwrup_latency", n, POWERUP_CYC);

    wait_sel(2, 400, n);
    check_val("rate_sel_seen", cur_sel(), 2);
    check_val("error_before_timeout", error, 0);
    starts = 0;
    for (int k = 0; k < 300; k++) begin
      if (spi_if.spi_start) starts++;
      else if (starts > 0) break;
      @(negedge clk);
    end
    check_val("timeout_req_cycles", starts, TIMEOUT_CYC);
    check_val("timeout_error", error, 1);
    check_val("timeout_sel_drop", cur_sel(), 0);
    check_val("timeout_init_done", init_done, 0);
    block_rate = 1'b0;
    n = 0;
    while (cur_sel() == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("restart_at_format", cur_sel(), 1);
    n = 0;
    while (!init_done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_val("reinit_done", init_done, 1);
    check_val("error_sticky", error, 1);

    check_val("onehot_violations", onehot_viol, 0);
    check_val("multi_cycle_valid", sv_multi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
